// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int unsigned NUM_REQ_DEF = 4;

  function automatic int unsigned id_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned ID_W = id_w(NUM_REQ_DEF);

  // Index that lies 'step' slots after 'base' on a ring of n entries (step <= n).
  function automatic int unsigned rr_next(input int unsigned base, input int unsigned step,
                                          input int unsigned n);
    int unsigned s;
    s = base + step;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_arbiter.sv
// Combinational rotate-priority picker: first requester after i_last, with wrap-around.
module rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N   = 4,
  parameter int unsigned IdW = 2
) (
  input  logic [N-1:0]   i_req,
  input  logic [IdW-1:0] i_last,
  output logic [IdW-1:0] o_sel,
  output logic           o_any
);

  logic [IdW-1:0] w_idx;

  always_comb begin
    o_sel = i_last;
    o_any = 1'b0;
    w_idx = '0;
    // Step k=N lands back on i_last, so the previous owner is considered last.
    for (int unsigned k = 1; k <= N; k++) begin
      w_idx = IdW'(rr_next(32'(i_last), k, N));
      if (!o_any && i_req[w_idx]) begin
        o_any = 1'b1;
        o_sel = w_idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready producers,
// granting bursts of up to MAX_BURST beats and never writing into a FIFO without room.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned CNT_W     = 9,
  parameter int unsigned FIFO_SIZE = 256,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [NUM_REQ-1:0]          i_req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   i_req_data,
  output logic [NUM_REQ-1:0]          o_req_ready,
  input  logic                        i_fifo_full,
  input  logic [CNT_W-1:0]            i_fifo_data_counter,
  output logic                        o_fifo_wr_en,
  output logic [DATA_W-1:0]           o_fifo_din,
  output logic [$clog2(NUM_REQ)-1:0]  o_grant_id,
  output logic                        o_busy
);

  localparam int unsigned IdW  = $clog2(NUM_REQ);
  localparam int unsigned BcW  = $clog2(MAX_BURST + 1);
  localparam int unsigned SumW = CNT_W + 1;

  arb_state_t r_state, w_state_d;

  logic [IdW-1:0]    r_owner, w_owner_d;
  logic [IdW-1:0]    r_last, w_last_d;
  logic [BcW-1:0]    r_beat_cnt, w_beat_d;
  logic              r_wr_en;
  logic [DATA_W-1:0] r_din;

  logic [IdW-1:0]     w_sel;
  logic               w_any;
  logic [SumW-1:0]    w_occ;
  logic               w_space_ok;
  logic [NUM_REQ-1:0] w_ready;
  logic               w_xfer;
  logic [IdW-1:0]     w_xfer_id;
  logic [DATA_W-1:0]  w_din;

  rr_arbiter #(
    .N   (NUM_REQ),
    .IdW (IdW)
  ) u_rr (
    .i_req  (i_req_valid),
    .i_last (r_last),
    .o_sel  (w_sel),
    .o_any  (w_any)
  );

  // The write already registered this cycle is not yet in the counter, so count it here.
  assign w_occ      = {1'b0, i_fifo_data_counter} + SumW'(r_wr_en);
  assign w_space_ok = !i_fifo_full && (w_occ < SumW'(FIFO_SIZE));

  assign w_xfer    = |(i_req_valid & w_ready);
  assign w_xfer_id = (r_state == IDLE) ? w_sel : r_owner;
  assign w_din     = i_req_data[w_xfer_id*DATA_W +: DATA_W];

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_owner    <= '0;
      r_last     <= IdW'(NUM_REQ - 1);
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_d;
      r_owner    <= w_owner_d;
      r_last     <= w_last_d;
      r_beat_cnt <= w_beat_d;
    end
  end

  // FSM next state.
  always_comb begin
    w_state_d = r_state;
    w_owner_d = r_owner;
    w_last_d  = r_last;
    w_beat_d  = r_beat_cnt;
    unique case (r_state)
      IDLE: begin
        if (w_xfer) begin
          w_owner_d = w_sel;
          w_beat_d  = BcW'(1);
          if (MAX_BURST > 1) begin
            w_state_d = BURST;
          end else begin
            w_last_d = w_sel;
          end
        end
      end
      BURST: begin
        if (!i_req_valid[r_owner]) begin
          // Owner ran dry: give up the port, costing one bubble cycle.
          w_state_d = IDLE;
          w_last_d  = r_owner;
        end else if (w_xfer) begin
          w_beat_d = r_beat_cnt + BcW'(1);
          if (int'(r_beat_cnt) + 1 == int'(MAX_BURST)) begin
            w_state_d = IDLE;
            w_last_d  = r_owner;
          end
        end
      end
      default: begin
        w_state_d = IDLE;
      end
    endcase
  end

  // FSM outputs.
  always_comb begin
    w_ready = '0;
    unique case (r_state)
      IDLE: begin
        if (w_any && w_space_ok) w_ready[w_sel] = 1'b1;
      end
      BURST: begin
        w_ready[r_owner] = w_space_ok;
      end
      default: begin
        w_ready = '0;
      end
    endcase
    o_req_ready = w_ready & {NUM_REQ{i_rst_n}};
    o_busy      = (r_state == BURST);
  end

  // FIFO write port registers; an accepted beat appears on the FIFO one cycle later.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_en <= 1'b0;
      r_din   <= '0;
    end else begin
      r_wr_en <= w_xfer;
      if (w_xfer) r_din <= w_din;
    end
  end

  assign o_fifo_wr_en = r_wr_en;
  assign o_fifo_din   = r_din;
  assign o_grant_id   = r_owner;

endmodule
